// File: rtl/nes_cpu_pkg.sv
`timescale 1ns/1ps
// nes_cpu_pkg
// Shared constants and decode helpers for the NES CPU front end.
//   MEM_ADDR_SIZE  : width of a byte address on the CPU bus
//   BYTE           : width of one memory byte
//   QDEPTH_DEFAULT : default depth of the fetch byte queue
//   addr_mode_e    : 6502 addressing modes, plus BRK and undefined opcodes
//   addr_mode()    : classifies an opcode byte into its addressing mode
//   instr_len()    : instruction length in bytes (1..3) for an opcode byte
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE  = 16;
  localparam int BYTE           = 8;
  localparam int QDEPTH_DEFAULT = 4;

  typedef enum logic [3:0] {
    AM_IMP,
    AM_ACC,
    AM_IMM,
    AM_ZP,
    AM_ZPX,
    AM_ZPY,
    AM_INDX,
    AM_INDY,
    AM_REL,
    AM_ABS,
    AM_ABSX,
    AM_ABSY,
    AM_IND,
    AM_BRK,
    AM_UNDEF
  } addr_mode_e;

  // The 6502 opcode map is laid out as aaa_bbb_cc: cc picks the opcode
  // group, bbb mostly picks the addressing mode within the group, and aaa
  // picks the operation. Holes in the official map decode to AM_UNDEF.
  function automatic addr_mode_e addr_mode(input logic [BYTE-1:0] op);
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] c;
    addr_mode_e m;
    a = op[7:5];
    b = op[4:2];
    c = op[1:0];
    m = AM_UNDEF;
    case (c)
      2'b01: begin
        case (b)
          3'b000: m = AM_INDX;
          3'b001: m = AM_ZP;
          3'b010: m = (op == 8'h89) ? AM_UNDEF : AM_IMM;
          3'b011: m = AM_ABS;
          3'b100: m = AM_INDY;
          3'b101: m = AM_ZPX;
          3'b110: m = AM_ABSY;
          default: m = AM_ABSX;
        endcase
      end
      2'b10: begin
        case (b)
          3'b000: m = (op == 8'hA2) ? AM_IMM : AM_UNDEF;
          3'b001: m = AM_ZP;
          // ASL/ROL/LSR/ROR act on A; TXA/TAX/DEX/NOP are implied
          3'b010: m = (a <= 3'd3) ? AM_ACC : AM_IMP;
          3'b011: m = AM_ABS;
          3'b100: m = AM_UNDEF;
          // STX/LDX index with Y instead of X
          3'b101: m = (a == 3'd4 || a == 3'd5) ? AM_ZPY : AM_ZPX;
          3'b110: m = (op == 8'h9A || op == 8'hBA) ? AM_IMP : AM_UNDEF;
          default: begin
            if (op == 8'hBE)      m = AM_ABSY;
            else if (op == 8'h9E) m = AM_UNDEF;
            else                  m = AM_ABSX;
          end
        endcase
      end
      2'b00: begin
        case (b)
          3'b000: begin
            case (a)
              3'd0:    m = AM_BRK;
              3'd1:    m = AM_ABS;   // JSR
              3'd2:    m = AM_IMP;   // RTI
              3'd3:    m = AM_IMP;   // RTS
              3'd4:    m = AM_UNDEF;
              default: m = AM_IMM;   // LDY/CPY/CPX #imm
            endcase
          end
          3'b001: m = (a == 3'd1 || a >= 3'd4) ? AM_ZP : AM_UNDEF;
          3'b010: m = AM_IMP;
          3'b011: begin
            if (a == 3'd0)      m = AM_UNDEF;
            else if (a == 3'd3) m = AM_IND;    // JMP (ind)
            else                m = AM_ABS;
          end
          3'b100: m = AM_REL;
          3'b101: m = (a == 3'd4 || a == 3'd5) ? AM_ZPX : AM_UNDEF;
          3'b110: m = AM_IMP;
          default: m = (op == 8'hBC) ? AM_ABSX : AM_UNDEF;
        endcase
      end
      default: m = AM_UNDEF;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] instr_len(input logic [BYTE-1:0] op);
    logic [1:0] len;
    case (addr_mode(op))
      AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_INDX, AM_INDY, AM_REL:
        len = 2'd2;
      AM_ABS, AM_ABSX, AM_ABSY, AM_IND:
        len = 2'd3;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue
// Circular byte queue feeding the instruction assembler. Up to one byte
// is pushed and up to three bytes are popped per cycle; a flush empties
// the queue and drops any push in the same cycle.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : empty the queue (wins over push and pop)
//   push_i            : write push_data_i at the tail
//   push_data_i       : byte to push
//   pop_cnt_i         : number of bytes (0..3) to drop from the head
//   count_o           : current occupancy, 0..DEPTH
//   head0_o..head2_o  : the three bytes at the head (only the first
//                       count_o of them are meaningful)
module fetch_queue
  import nes_cpu_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEFAULT,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [BYTE-1:0] push_data_i,
  input  logic [1:0]      pop_cnt_i,
  output logic [CW-1:0]   count_o,
  output logic [BYTE-1:0] head0_o,
  output logic [BYTE-1:0] head1_o,
  output logic [BYTE-1:0] head2_o
);

  localparam int PW = $clog2(DEPTH);

  logic [BYTE-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_p1, rd_ptr_p2;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
    wr_ptr_d = push_i ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    count_d  = count_q - CW'(pop_cnt_i) + CW'(push_i);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: bytes are only observed through count_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    rd_ptr_p1 = rd_ptr_q + PW'(1);
    rd_ptr_p2 = rd_ptr_q + PW'(2);
  end

  assign count_o = count_q;
  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_p1];
  assign head2_o = mem_q[rd_ptr_p2];

endmodule

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
// Byte-wide instruction prefetcher for a 6502-style core. Reads one byte
// per cycle from a fixed one-cycle-latency memory into a small queue and
// presents whole instructions (1..3 bytes) to decode.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   mem_rd_o         : byte read request
//   mem_addr_o       : read address (fetch PC)
//   mem_data_i       : read data, one cycle after mem_rd_o
//   redirect_i       : branch/jump/interrupt redirect pulse
//   redirect_pc_i    : new fetch address for the redirect
//   instr_valid_o    : a complete instruction is presented
//   instr_ready_i    : decode accepts the presented instruction
//   instr_o          : {operand2, operand1, opcode}, unused bytes zero
//   instr_len_o      : instruction length 1..3
//   instr_pc_o       : address of the opcode byte
//
// Handshake: an instruction transfers on every rising edge where
// instr_valid_o and instr_ready_i are both high. instr_valid_o does not
// depend on instr_ready_i, and once raised it stays high with instr_o,
// instr_len_o and instr_pc_o unchanged until the transfer happens (a
// redirect or reset is the only thing that may withdraw it).
module fetch_unit
  import nes_cpu_pkg::*;
#(
  parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC = '0,
  parameter int                       QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     mem_rd_o,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic [BYTE-1:0]          mem_data_i,
  input  logic                     redirect_i,
  input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [3*BYTE-1:0]        instr_o,
  output logic [1:0]               instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0] instr_pc_o
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = CW + 1;

  logic [MEM_ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
  logic                     inflight_q, inflight_d;

  logic [CW-1:0]   count;
  logic [BYTE-1:0] head0, head1, head2;
  logic [1:0]      head_len;
  logic            valid;
  logic            fire;
  logic [1:0]      pop_cnt;
  logic [OW-1:0]   occ_after;
  logic            issue;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (inflight_q),
    .push_data_i (mem_data_i),
    .pop_cnt_i   (pop_cnt),
    .count_o     (count),
    .head0_o     (head0),
    .head1_o     (head1),
    .head2_o     (head2)
  );

  // An empty queue has no meaningful head byte; report length 1 so the
  // length output is well defined and valid needs at least one byte.
  always_comb begin
    head_len = (count == '0) ? 2'd1 : instr_len(head0);
    valid    = (count >= CW'(head_len));
    fire     = valid && instr_ready_i;
    pop_cnt  = fire ? head_len : 2'd0;
  end

  // Issue only if every byte already owned (queued after this cycle's pop,
  // plus the one in flight) and the new one still fit in the queue. This
  // is what makes queue overflow impossible. Reset gates the request
  // directly so the first read goes out as soon as reset drops.
  always_comb begin
    occ_after = OW'(count) - OW'(pop_cnt) + OW'(inflight_q) + OW'(1);
    issue     = !rst_i && !redirect_i && (occ_after <= OW'(QDEPTH));
  end

  // A redirect overrides the PC advance of a same-cycle handshake: the
  // accepted instruction is gone, and the queue restarts at the target.
  // Dropping inflight_q squashes the return that lands in the redirect
  // cycle (the queue flush discards that push).
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inflight_d = issue;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + MEM_ADDR_SIZE'(1);
    end
    if (fire) begin
      pc_d = pc_q + MEM_ADDR_SIZE'(head_len);
    end
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      pc_d       = redirect_pc_i;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Operand bytes beyond the instruction length are forced to zero so
  // decode never sees the next instruction's bytes.
  always_comb begin
    instr_o = '0;
    if (valid) begin
      instr_o[BYTE-1:0] = head0;
      if (head_len >= 2'd2) instr_o[2*BYTE-1:BYTE]   = head1;
      if (head_len == 2'd3) instr_o[3*BYTE-1:2*BYTE] = head2;
    end
  end

  assign mem_rd_o      = issue;
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = valid;
  assign instr_len_o   = head_len;
  assign instr_pc_o    = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int QD = 4;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  logic        rst2;
  logic        mem_rd2;
  logic [15:0] mem_addr2;
  logic [7:0]  mem_data2;
  logic        redirect2;
  logic [15:0] redirect_pc2;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [23:0] instr2;
  logic [1:0]  instr_len2;
  logic [15:0] instr_pc2;

  logic [7:0] mem [65536];

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(QD)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_rd_o      (mem_rd),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_len_o   (instr_len),
    .instr_pc_o    (instr_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .QDEPTH(QD)) dut_wrap (
    .clk_i         (clk),
    .rst_i         (rst2),
    .mem_rd_o      (mem_rd2),
    .mem_addr_o    (mem_addr2),
    .mem_data_i    (mem_data2),
    .redirect_i    (redirect2),
    .redirect_pc_i (redirect_pc2),
    .instr_valid_o (instr_valid2),
    .instr_ready_i (instr_ready2),
    .instr_o       (instr2),
    .instr_len_o   (instr_len2),
    .instr_pc_o    (instr_pc2)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= mem[mem_addr];
    if (mem_rd2) mem_data2 <= mem[mem_addr2];
  end

  // Queue must never exceed its depth.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (dut.u_queue.count_o > 3'(QD)) begin
        errors++;
        $display("FAIL overflow: count %0d exceeds %0d", dut.u_queue.count_o, QD);
      end
    end
    if (rst2 === 1'b0) begin
      checks++;
      if (dut_wrap.u_queue.count_o > 3'(QD)) begin
        errors++;
        $display("FAIL overflow_wrap: count %0d exceeds %0d", dut_wrap.u_queue.count_o, QD);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++;
    if (instr !== 24'h0) begin errors++; $display("FAIL reset_instr: got %h want 000000", instr); end
    checks++;
    if (instr_len !== 2'd1) begin errors++; $display("FAIL reset_len: got %0d want 1", instr_len); end
    checks++;
    if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_fetch_pc: got %h want 0000", mem_addr); end
  endtask

  task automatic test_basic_stream();
    logic [23:0] e_instr [3];
    logic [1:0]  e_len [3];
    logic [15:0] e_pc [3];
    int budget;
    e_instr = '{24'h0005A9, 24'h02008D, 24'h0000EA};
    e_len   = '{2'd2, 2'd3, 2'd1};
    e_pc    = '{16'h0000, 16'h0002, 16'h0005};
    rst = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL first_read: got rd=%b addr=%h want rd=1 addr=0000", mem_rd, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid=%b want 0", instr_valid); end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL latency: valid=%b want 1", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      budget = 0;
      while (!(instr_valid && instr_ready) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL basic_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr !== e_instr[k] || instr_len !== e_len[k] || instr_pc !== e_pc[k]) begin
        errors++;
        $display("FAIL basic_instr[%0d]: got %h len %0d pc %h want %h len %0d pc %h",
                 k, instr, instr_len, instr_pc, e_instr[k], e_len[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [23:0] e_instr [4];
    logic [1:0]  e_len [4];
    logic [15:0] e_pc [4];
    logic [23:0] snap_instr;
    logic [1:0]  snap_len;
    logic [15:0] snap_pc;
    logic        seen;
    int budget;
    e_instr = '{24'h0005A9, 24'h02008D, 24'h0000EA, 24'h0000EA};
    e_len   = '{2'd2, 2'd3, 2'd1, 2'd1};
    e_pc    = '{16'h0000, 16'h0002, 16'h0005, 16'h0006};
    snap_instr = '0; snap_len = '0; snap_pc = '0; seen = 1'b0;
    rst = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (!seen) begin
          snap_instr = instr; snap_len = instr_len; snap_pc = instr_pc; seen = 1'b1;
        end else begin
          checks++;
          if (instr !== snap_instr || instr_len !== snap_len || instr_pc !== snap_pc) begin
            errors++;
            $display("FAIL stall_stable[%0d]: got %h/%0d/%h want %h/%0d/%h",
                     c, instr, instr_len, instr_pc, snap_instr, snap_len, snap_pc);
          end
        end
      end
    end
    checks++;
    if (snap_instr !== 24'h0005A9 || snap_len !== 2'd2 || snap_pc !== 16'h0000) begin
      errors++; $display("FAIL stall_head: got %h/%0d/%h want 0005a9/2/0000", snap_instr, snap_len, snap_pc);
    end
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL stall_mem_rd: got %b want 0", mem_rd); end
    checks++;
    if (dut.u_queue.count_o !== 3'(QD)) begin
      errors++; $display("FAIL stall_occupancy: got %0d want %0d", dut.u_queue.count_o, QD);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      budget = 0;
      while (!(instr_valid && instr_ready) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL stall_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr !== e_instr[k] || instr_len !== e_len[k] || instr_pc !== e_pc[k]) begin
        errors++;
        $display("FAIL stall_resume[%0d]: got %h len %0d pc %h want %h len %0d pc %h",
                 k, instr, instr_len, instr_pc, e_instr[k], e_len[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_inflight();
    logic [23:0] e_instr [8];
    logic [1:0]  e_len [8];
    logic [15:0] e_pc [8];
    int budget;
    e_instr = '{24'h007FA2, 24'h12346C, 24'h00000A, 24'h0010B1,
                24'h000002, 24'h000000, 24'h0300BD, 24'h0000EA};
    e_len   = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd3, 2'd1};
    e_pc    = '{16'h0040, 16'h0042, 16'h0045, 16'h0046,
                16'h0048, 16'h0049, 16'h004A, 16'h004D};
    rst = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin
      errors++; $display("FAIL redir_pre: got rd=%b addr=%h want rd=1 addr=0001", mem_rd, mem_addr);
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL redir_no_read: got rd=%b want 0", mem_rd); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr_pc !== 16'h0040) begin
      errors++; $display("FAIL redir_state: got valid=%b pc=%h want valid=0 pc=0040", instr_valid, instr_pc);
    end
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin
      errors++; $display("FAIL redir_fetch: got rd=%b addr=%h want rd=1 addr=0040", mem_rd, mem_addr);
    end
    for (int k = 0; k < 8; k++) begin
      budget = 0;
      while (!(instr_valid && instr_ready) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL redir_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr !== e_instr[k] || instr_len !== e_len[k] || instr_pc !== e_pc[k]) begin
        errors++;
        $display("FAIL redir_instr[%0d]: got %h len %0d pc %h want %h len %0d pc %h",
                 k, instr, instr_len, instr_pc, e_instr[k], e_len[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_redirect();
    logic [23:0] e_instr [2];
    logic [15:0] e_pc [2];
    int budget;
    e_instr = '{24'h007FA2, 24'h12346C};
    e_pc    = '{16'h0040, 16'h0042};
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0000;
    @(negedge clk);
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (instr_pc !== 16'h0040) begin errors++; $display("FAIL b2b_pc: got %h want 0040", instr_pc); end
    for (int k = 0; k < 2; k++) begin
      budget = 0;
      while (!(instr_valid && instr_ready) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL b2b_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr !== e_instr[k] || instr_pc !== e_pc[k]) begin
        errors++;
        $display("FAIL b2b_instr[%0d]: got %h pc %h want %h pc %h", k, instr, instr_pc, e_instr[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_handshake();
    logic [23:0] e_instr [2];
    logic [15:0] e_pc [2];
    int budget;
    e_instr = '{24'h00000A, 24'h0010B1};
    e_pc    = '{16'h0045, 16'h0046};
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    budget = 0;
    while (!instr_valid && budget < 30) begin @(negedge clk); budget++; end
    checks++;
    if (budget >= 30 || instr_pc !== 16'h0040 || instr !== 24'h007FA2) begin
      errors++; $display("FAIL hs_setup: got %h pc %h want 007fa2 pc 0040", instr, instr_pc);
    end
    // Handshake and redirect on the same edge.
    redirect = 1'b1; redirect_pc = 16'h0045;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (instr_pc !== 16'h0045) begin errors++; $display("FAIL hs_redirect_pc: got %h want 0045", instr_pc); end
    for (int k = 0; k < 2; k++) begin
      budget = 0;
      while (!(instr_valid && instr_ready) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL hs_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr !== e_instr[k] || instr_pc !== e_pc[k]) begin
        errors++;
        $display("FAIL hs_instr[%0d]: got %h pc %h want %h pc %h", k, instr, instr_pc, e_instr[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e_instr [2];
    logic [15:0] e_pc [2];
    int budget;
    e_instr = '{24'h0005A9, 24'h02008D};
    e_pc    = '{16'h0000, 16'h0002};
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (dut.u_queue.count_o !== 3'(QD) || instr_pc !== 16'h0040) begin
      errors++; $display("FAIL areset_full: count %0d pc %h want %0d pc 0040", dut.u_queue.count_o, instr_pc, QD);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL areset_ctl: valid=%b rd=%b want 0 0", instr_valid, mem_rd);
    end
    checks++;
    if (instr !== 24'h0 || instr_len !== 2'd1 || instr_pc !== 16'h0000) begin
      errors++; $display("FAIL areset_out: got %h/%0d/%h want 000000/1/0000", instr, instr_len, instr_pc);
    end
    checks++;
    if (dut.u_queue.count_o !== 3'd0 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL areset_state: count %0d addr %h want 0 0000", dut.u_queue.count_o, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      budget = 0;
      while (!(instr_valid && instr_ready) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL areset_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr !== e_instr[k] || instr_pc !== e_pc[k]) begin
        errors++;
        $display("FAIL areset_restart[%0d]: got %h pc %h want %h pc %h", k, instr, instr_pc, e_instr[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pc_wrap();
    logic [23:0] e_instr [2];
    logic [15:0] e_pc [2];
    int budget;
    e_instr = '{24'h05A9AD, 24'h02008D};
    e_pc    = '{16'hFFFF, 16'h0002};
    instr_ready2 = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_pc2 !== 16'hFFFF || mem_rd2 !== 1'b0) begin
      errors++; $display("FAIL wrap_reset: pc %h rd %b want ffff 0", instr_pc2, mem_rd2);
    end
    rst2 = 1'b0;
    #1;
    checks++;
    if (mem_rd2 !== 1'b1 || mem_addr2 !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_first_read: rd=%b addr=%h want rd=1 addr=ffff", mem_rd2, mem_addr2);
    end
    @(negedge clk);
    checks++;
    if (mem_rd2 !== 1'b1 || mem_addr2 !== 16'h0000) begin
      errors++; $display("FAIL wrap_fetch_pc: rd=%b addr=%h want rd=1 addr=0000", mem_rd2, mem_addr2);
    end
    for (int k = 0; k < 2; k++) begin
      budget = 0;
      while (!(instr_valid2 && instr_ready2) && budget < 30) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 30) begin
        errors++; $display("FAIL wrap_timeout[%0d]: no instruction in 30 cycles", k);
      end else if (instr2 !== e_instr[k] || instr_len2 !== 2'd3 || instr_pc2 !== e_pc[k]) begin
        errors++;
        $display("FAIL wrap_instr[%0d]: got %h len %0d pc %h want %h len 3 pc %h",
                 k, instr2, instr_len2, instr_pc2, e_instr[k], e_pc[k]);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; rst2 = 1'b1;
    instr_ready = 1'b0; instr_ready2 = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000;
    redirect2 = 1'b0; redirect_pc2 = 16'h0000;
    mem_data = 8'h00; mem_data2 = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h05; mem[16'h0002] = 8'h8D;
    mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h02; mem[16'h0005] = 8'hEA;
    mem[16'h0040] = 8'hA2; mem[16'h0041] = 8'h7F;
    mem[16'h0042] = 8'h6C; mem[16'h0043] = 8'h34; mem[16'h0044] = 8'h12;
    mem[16'h0045] = 8'h0A;
    mem[16'h0046] = 8'hB1; mem[16'h0047] = 8'h10;
    mem[16'h0048] = 8'h02;
    mem[16'h0049] = 8'h00;
    mem[16'h004A] = 8'hBD; mem[16'h004B] = 8'h00; mem[16'h004C] = 8'h03;
    mem[16'hFFFF] = 8'hAD;

    test_reset();
    test_basic_stream();
    test_stall();
    test_redirect_inflight();
    test_back_to_back_redirect();
    test_redirect_handshake();
    test_async_reset();
    test_pc_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter QDEPTH, default 4, giving the prefetch byte-queue depth; legal values are powers of two and at least 3.
REQ-003 The block SHALL have clk_i  in  1  the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have rst_i  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have mem_rd_o  out  1  byte read request to memory.
REQ-006 The block SHALL have mem_addr_o  out  MEM_ADDR_SIZE  read address, valid while mem_rd_o=1.
REQ-007 The block SHALL have mem_data_i  in  8  read data, returned exactly one cycle after each mem_rd_o=1; memory never stalls.
REQ-008 The block SHALL have redirect_i  in  1  branch/jump/interrupt redirect pulse.
REQ-009 The block SHALL have redirect_pc_i  in  MEM_ADDR_SIZE  new fetch address, sampled when redirect_i=1.
REQ-010 The block SHALL have instr_valid_o  out  1  a complete instruction is presented.
REQ-011 The block SHALL have instr_ready_i  in  1  decode accepts the instruction.
REQ-012 The block SHALL have instr_o  out  24  instruction bytes: opcode in [7:0], operand 1 in [15:8], operand 2 in [23:16]; unused bytes are zero.
REQ-013 The block SHALL have instr_len_o  out  2  instruction length, 1 to 3.
REQ-014 The block SHALL have instr_pc_o  out  MEM_ADDR_SIZE  address of the opcode byte.

Function
REQ-015 The block SHALL keep fetch_pc, a byte queue of QDEPTH entries, an occupancy counter and one in-flight flag.
REQ-016 The block SHALL assert mem_rd_o, with mem_addr_o=fetch_pc, in every cycle where occupancy + in-flight + (1 if a read is issued) does not exceed QDEPTH after that cycle's pops, and no redirect_i is asserted.
REQ-017 On each issued read, the block SHALL increment fetch_pc modulo 2^MEM_ADDR_SIZE, wrapping from all-ones to 0.
REQ-018 The block SHALL push the returned mem_data_i into the queue tail in the cycle after issue, unless that read has been squashed.
REQ-019 The block SHALL determine instruction length combinationally from the head byte using the package function: implied/accumulator = 1; immediate, zero-page, zero-page-indexed, (ind,X), (ind),Y and relative = 2; absolute, absolute-indexed and indirect = 3; BRK = 1; undefined opcodes = 1.
REQ-020 The block SHALL assert instr_valid_o exactly when occupancy >= length of the head opcode.
REQ-021 The outputs instr_o, instr_len_o and instr_pc_o SHALL be driven directly from queue and PC state, with no bubble.
REQ-022 On instr_valid_o and instr_ready_i both high, the block SHALL pop instr_len_o bytes and advance instr_pc_o by instr_len_o modulo 2^MEM_ADDR_SIZE.
REQ-023 While a handshake is pending, instr_o, instr_len_o and instr_pc_o SHALL hold stable.
REQ-024 A pop and a push in the same cycle SHALL both take effect, with the new occupancy = occupancy - len + 1.
REQ-025 Best case, the first instruction SHALL become valid len+1 cycles after the first mem_rd_o (one-cycle memory latency, one byte per cycle).
REQ-026 On redirect_i, the block SHALL, in the next cycle: empty the queue, squash any in-flight return, and set fetch_pc and instr_pc_o to redirect_pc_i; it SHALL issue no read in the redirect cycle.
REQ-027 When redirect_i coincides with a handshake, the handshake SHALL complete and the redirect SHALL then take priority for the queue contents.
REQ-028 Back-to-back redirect_i SHALL be honoured, with the last one winning.
REQ-029 Queue pointers SHALL wrap modulo QDEPTH; overflow is impossible by REQ-016, and the bench asserts this.

Reset
REQ-030 While rst_i is high, the block SHALL hold fetch_pc=RESET_PC, instr_pc_o=RESET_PC, occupancy=0, in-flight=0, mem_rd_o=0, instr_valid_o=0, instr_o=0 and instr_len_o=1.
REQ-031 The first read SHALL be issued in the first cycle after rst_i deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all queued and in-flight bytes.

Structure
REQ-033 The package nes_cpu_pkg SHALL hold the instruction length function, the addressing-mode enum and the QDEPTH default; MEM_ADDR_SIZE and BYTE are reused from it.
REQ-034 The byte queue SHALL be a sub-module, fetch_queue, with push, pop-count 0-3, occupancy and three head-byte outputs.

Verification
REQ-035 Scenario: bytes A9 05 8D 00 02 EA at address 0, ready=1 -> emit 0x0005A9 len 2 at pc 0, 0x02008D len 3 at pc 2, 0x0000EA len 1 at pc 5.
REQ-036 Scenario: ready=0 for 10 cycles after reset -> occupancy saturates at QDEPTH, mem_rd_o=0, outputs stable; ready=1 then resumes fetch with no lost byte.
REQ-037 Scenario: redirect_i to 0x0040 while a read is in flight -> the squashed byte is never output, and the next instruction has instr_pc_o=0x0040.
REQ-038 Scenario: RESET_PC = all-ones with a 3-byte opcode there -> operands are fetched from 0 and 1, and instr_pc_o then wraps to 2.
REQ-039 Scenario: rst_i asserted asynchronously mid-cycle with a full queue -> outputs reach reset values immediately, and fetch restarts at RESET_PC.
